// File: rtl/cpu_store_buffer_if.sv
// rtl/cpu_store_buffer_if.sv - store buffer bus bundle
// Purpose: groups the writeback push side, memory drain side and forwarding
//          lookup signals of cpu_store_buffer into one interface.
// Modports:
//   slave  - the store buffer itself (consumes pushes/acks/load address,
//            drives status, memory request and forwarding result)
//   master - the surrounding pipeline/memory environment
// Signals:
//   memory_write_enable_i/address_i/value_i  push request from writeback
//   full_o, empty_o, overflow_o              buffer status
//   mem_write_o, mem_address_o, mem_value_o  head entry write request
//   mem_ack_i                                memory accepted the head
//   load_address_i, load_hit_o, load_value_o forwarding lookup
interface cpu_store_buffer_if;
    logic        memory_write_enable_i;
    logic [31:0] memory_write_address_i;
    logic [31:0] memory_write_value_i;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_value_o;
    logic        mem_ack_i;
    logic [31:0] load_address_i;
    logic        load_hit_o;
    logic [31:0] load_value_o;

    modport slave (
        input  memory_write_enable_i,
        input  memory_write_address_i,
        input  memory_write_value_i,
        output full_o,
        output empty_o,
        output overflow_o,
        output mem_write_o,
        output mem_address_o,
        output mem_value_o,
        input  mem_ack_i,
        input  load_address_i,
        output load_hit_o,
        output load_value_o
    );

    modport master (
        output memory_write_enable_i,
        output memory_write_address_i,
        output memory_write_value_i,
        input  full_o,
        input  empty_o,
        input  overflow_o,
        input  mem_write_o,
        input  mem_address_o,
        input  mem_value_o,
        output mem_ack_i,
        output load_address_i,
        input  load_hit_o,
        input  load_value_o
    );
endinterface

// File: rtl/cpu_store_buffer.sv
// rtl/cpu_store_buffer.sv - posted-write store FIFO with optional load forwarding
// Purpose: buffers stores from writeback and drains them to memory in order
//          over a req/ack handshake; full_o stalls the pipeline.
// Parameters: DEPTH_LOG2 (1..4) - log2 of the entry count.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - cpu_store_buffer_if.slave (push, status, drain, forwarding)
// Option macro: CPU_STORE_FORWARD_EN - builds the store-to-load forwarding
//   comparators; when undefined load_hit_o/load_value_o are tied to 0.
module cpu_store_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cpu_store_buffer_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [31:0]           addr_q  [DEPTH];
    logic [31:0]           value_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Status comes straight from the registered count so it cannot glitch
    // on input activity.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A pop frees a slot on the same edge, so a push while full is still
    // accepted when the head is being acked.
    assign pop  = !empty && bus.mem_ack_i;
    assign push = bus.memory_write_enable_i && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (bus.memory_write_enable_i && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                addr_q[wr_ptr_q]  <= bus.memory_write_address_i;
                value_q[wr_ptr_q] <= bus.memory_write_value_i;
            end
        end
    end

    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.overflow_o  = overflow_q;
    assign bus.mem_write_o = !empty;
    // Popped slots keep stale data, so the head is masked when empty.
    assign bus.mem_address_o = empty ? 32'd0 : addr_q[rd_ptr_q];
    assign bus.mem_value_o   = empty ? 32'd0 : value_q[rd_ptr_q];

`ifdef CPU_STORE_FORWARD_EN
    logic                  fwd_hit;
    logic [31:0]           fwd_value;
    logic [DEPTH_LOG2-1:0] fwd_idx;

    // Walk valid entries oldest to youngest; a later match overrides an
    // earlier one so the youngest store wins.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_value = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + DEPTH_LOG2'(i);
            if (((DEPTH_LOG2 + 1)'(i) < count_q) &&
                (addr_q[fwd_idx] == bus.load_address_i)) begin
                fwd_hit   = 1'b1;
                fwd_value = value_q[fwd_idx];
            end
        end
    end

    assign bus.load_hit_o   = fwd_hit;
    assign bus.load_value_o = fwd_value;
`else
    logic unused_load_address;
    assign unused_load_address = ^bus.load_address_i;
    assign bus.load_hit_o      = 1'b0;
    assign bus.load_value_o    = '0;
`endif

endmodule
